// File: rtl/prbs8_checker.sv
// Receive-side checker for the 8-bit LFSR randomizer: self-synchronises to the
// incoming word stream, counts mispredictions while locked and shows the count on 7-seg.
module prbs8_checker #(
  parameter int unsigned LOCK_CNT = 4,
  parameter int unsigned LOSS_CNT = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       valid,
  input  logic [7:0] data_in,
  input  logic       clr_err,
  output logic       locked,
  output logic [7:0] err_cnt,
  output logic [7:0] seg_lo,
  output logic [7:0] seg_hi
);

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } state_t;

  localparam logic [3:0] LOCK_LAST = 4'(LOCK_CNT - 1);
  localparam logic [3:0] LOSS_LAST = 4'(LOSS_CNT - 1);

  state_t     state_r, state_s;
  logic [7:0] expected_r, expected_s;
  logic [3:0] match_cnt_r, match_cnt_s;
  logic [3:0] miss_cnt_r, miss_cnt_s;
  logic [7:0] err_cnt_r, err_cnt_s;
  logic [7:0] err_step_s;
  logic       locked_r, locked_s;

  // Word-to-word step of the randomizer; all-zero is a lock-up state the generator escapes to 01.
  function automatic logic [7:0] nx(input logic [7:0] x);
    logic [7:0] y;
    if (x == 8'h00) begin
      y = 8'h01;
    end else begin
      y = {x[3] ^ x[2] ^ x[1] ^ x[0], x[7:1]};
    end
    return y;
  endfunction

  function automatic logic [7:0] seg7(input logic [3:0] n);
    logic [7:0] s;
    case (n)
      4'h0: s = 8'h02;
      4'h1: s = 8'h9E;
      4'h2: s = 8'h24;
      4'h3: s = 8'h0C;
      4'h4: s = 8'h98;
      4'h5: s = 8'h48;
      4'h6: s = 8'h40;
      4'h7: s = 8'h1E;
      4'h8: s = 8'h00;
      4'h9: s = 8'h08;
      4'hA: s = 8'h10;
      4'hB: s = 8'hC0;
      4'hC: s = 8'h62;
      4'hD: s = 8'h84;
      4'hE: s = 8'h60;
      4'hF: s = 8'h70;
      default: s = 8'hFF;
    endcase
    return s;
  endfunction

  // Next-state, prediction and error-count logic for the HUNT/VERIFY/LOCKED tracker.
  always_comb begin
    state_s     = state_r;
    expected_s  = expected_r;
    match_cnt_s = match_cnt_r;
    miss_cnt_s  = miss_cnt_r;
    err_step_s  = err_cnt_r;
    if (valid) begin
      case (state_r)
        HUNT: begin
          if (data_in != 8'h00) begin
            expected_s  = nx(data_in);
            match_cnt_s = 4'd0;
            state_s     = VERIFY;
          end else begin
            state_s = HUNT;
          end
        end
        VERIFY: begin
          if (data_in == expected_r) begin
            expected_s  = nx(expected_r);
            match_cnt_s = match_cnt_r + 4'd1;
            if (match_cnt_r == LOCK_LAST) begin
              state_s    = LOCKED;
              miss_cnt_s = 4'd0;
            end else begin
              state_s = VERIFY;
            end
          end else if (data_in != 8'h00) begin
            expected_s  = nx(data_in);
            match_cnt_s = 4'd0;
            state_s     = VERIFY;
          end else begin
            state_s = HUNT;
          end
        end
        LOCKED: begin
          // Flywheel: the prediction advances even on a bad word so one hit does not cascade.
          expected_s = nx(expected_r);
          if (data_in == expected_r) begin
            miss_cnt_s = 4'd0;
          end else begin
            if (err_cnt_r != 8'hFF) begin
              err_step_s = err_cnt_r + 8'd1;
            end else begin
              err_step_s = err_cnt_r;
            end
            if (miss_cnt_r == LOSS_LAST) begin
              state_s     = HUNT;
              match_cnt_s = 4'd0;
              miss_cnt_s  = 4'd0;
            end else begin
              miss_cnt_s = miss_cnt_r + 4'd1;
            end
          end
        end
        default: begin
          state_s     = HUNT;
          match_cnt_s = 4'd0;
          miss_cnt_s  = 4'd0;
        end
      endcase
    end else begin
      state_s = state_r;
    end
    err_cnt_s = clr_err ? 8'h00 : err_step_s;
    locked_s  = (state_s == LOCKED);
  end

  // State and counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= HUNT;
      expected_r  <= 8'h00;
      match_cnt_r <= 4'd0;
      miss_cnt_r  <= 4'd0;
      err_cnt_r   <= 8'h00;
      locked_r    <= 1'b0;
    end else begin
      state_r     <= state_s;
      expected_r  <= expected_s;
      match_cnt_r <= match_cnt_s;
      miss_cnt_r  <= miss_cnt_s;
      err_cnt_r   <= err_cnt_s;
      locked_r    <= locked_s;
    end
  end

  assign locked  = locked_r;
  assign err_cnt = err_cnt_r;
  assign seg_lo  = seg7(err_cnt_r[3:0]);
  assign seg_hi  = seg7(err_cnt_r[7:4]);

endmodule

// File: tb/tb_prbs8_checker.sv
// Scoreboard bench for prbs8_checker: a reference model queues the expected
// outputs for every driven cycle and a monitor compares them after each edge.
module tb_prbs8_checker;

  localparam int LOCK = 4;
  localparam int LOSS = 3;

  logic       clk;
  logic       rst_n;
  logic       valid;
  logic [7:0] data_in;
  logic       clr_err;
  logic       locked;
  logic [7:0] err_cnt;
  logic [7:0] seg_lo;
  logic [7:0] seg_hi;

  prbs8_checker #(.LOCK_CNT(LOCK), .LOSS_CNT(LOSS)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .valid   (valid),
    .data_in (data_in),
    .clr_err (clr_err),
    .locked  (locked),
    .err_cnt (err_cnt),
    .seg_lo  (seg_lo),
    .seg_hi  (seg_hi)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic       lk;
    logic [7:0] err;
    logic [7:0] slo;
    logic [7:0] shi;
  } obs_t;

  obs_t  sb_q[$];
  obs_t  mon_exp, mon_act;
  int    checks = 0;
  int    errors = 0;
  int    step_no = 0;
  string cur_test = "init";

  logic [7:0] seg_tbl [16] = '{8'h02, 8'h9E, 8'h24, 8'h0C, 8'h98, 8'h48, 8'h40, 8'h1E,
                               8'h00, 8'h08, 8'h10, 8'hC0, 8'h62, 8'h84, 8'h60, 8'h70};

  // reference model state: 0=hunt 1=verify 2=locked
  int         m_state;
  logic [7:0] m_exp;
  int         m_match, m_miss;
  logic [7:0] m_err;

  function automatic logic [7:0] ref_nx(input logic [7:0] x);
    if (x == 8'h00) return 8'h01;
    return {x[3] ^ x[2] ^ x[1] ^ x[0], x[7:1]};
  endfunction

  task automatic model_reset();
    m_state = 0; m_exp = 8'h00; m_match = 0; m_miss = 0; m_err = 8'h00;
  endtask

  task automatic model_step(input logic v, input logic [7:0] d, input logic clr);
    obs_t e;
    logic hit;
    if (v) begin
      case (m_state)
        0: if (d != 8'h00) begin m_exp = ref_nx(d); m_match = 0; m_state = 1; end
        1: begin
          if (d == m_exp) begin
            m_exp = ref_nx(m_exp);
            m_match++;
            if (m_match == LOCK) begin m_state = 2; m_miss = 0; end
          end else if (d != 8'h00) begin
            m_exp = ref_nx(d); m_match = 0;
          end else begin
            m_state = 0;
          end
        end
        default: begin
          hit = (d == m_exp);
          m_exp = ref_nx(m_exp);
          if (hit) m_miss = 0;
          else begin
            if (m_err != 8'hFF) m_err = m_err + 8'd1;
            m_miss++;
            if (m_miss == LOSS) begin m_state = 0; m_match = 0; m_miss = 0; end
          end
        end
      endcase
    end
    if (clr) m_err = 8'h00;
    e.lk  = (m_state == 2);
    e.err = m_err;
    e.slo = seg_tbl[m_err[3:0]];
    e.shi = seg_tbl[m_err[7:4]];
    sb_q.push_back(e);
  endtask

  // drive one cycle, queue its expected outcome, return 3 time units after the sampling edge
  task automatic step(input logic v, input logic [7:0] d, input logic clr);
    valid = v; data_in = d; clr_err = clr;
    model_step(v, d, clr);
    @(posedge clk);
    #3;
    valid = 1'b0; clr_err = 1'b0;
  endtask

  // scoreboard consumer: compares the oldest queued expectation after each edge
  always @(posedge clk) begin
    if (sb_q.size() > 0) begin
      #2;
      mon_exp = sb_q.pop_front();
      mon_act = {locked, err_cnt, seg_lo, seg_hi};
      step_no++;
      checks++;
      if (mon_act !== mon_exp) begin
        errors++;
        $display("FAIL %s step%0d: got locked=%b err=%h seg_lo=%h seg_hi=%h, need locked=%b err=%h seg_lo=%h seg_hi=%h",
                 cur_test, step_no, mon_act.lk, mon_act.err, mon_act.slo, mon_act.shi,
                 mon_exp.lk, mon_exp.err, mon_exp.slo, mon_exp.shi);
      end
    end
  end

  task automatic apply_reset();
    rst_n = 1'b0; valid = 1'b0; data_in = 8'h00; clr_err = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #3;
  endtask

  task automatic lock_up();
    step(1'b1, 8'h01, 1'b0);
    step(1'b1, 8'h80, 1'b0);
    step(1'b1, 8'h40, 1'b0);
    step(1'b1, 8'h20, 1'b0);
    step(1'b1, 8'h10, 1'b0);
  endtask

  task automatic test_reset();
    cur_test = "reset";
    apply_reset();
    checks++;
    if ({locked, err_cnt, seg_lo, seg_hi} !== {1'b0, 8'h00, 8'h02, 8'h02}) begin
      errors++;
      $display("FAIL reset_state: got %b/%h/%h/%h, need 0/00/02/02", locked, err_cnt, seg_lo, seg_hi);
    end
  endtask

  task automatic test_mid_reset();
    cur_test = "mid_reset";
    apply_reset();
    lock_up();
    for (int i = 0; i < 5; i++) begin
      step(1'b1, ~m_exp, 1'b0);
      step(1'b1, m_exp, 1'b0);
    end
    checks++;
    if (err_cnt !== 8'h05 || locked !== 1'b1) begin
      errors++;
      $display("FAIL mid_reset_setup: got locked=%b err=%h, need 1/05", locked, err_cnt);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({locked, err_cnt, seg_lo, seg_hi} !== {1'b0, 8'h00, 8'h02, 8'h02}) begin
      errors++;
      $display("FAIL mid_reset_async: got %b/%h/%h/%h, need 0/00/02/02", locked, err_cnt, seg_lo, seg_hi);
    end
    apply_reset();
  endtask

  task automatic test_acquire();
    cur_test = "acquire";
    apply_reset();
    step(1'b1, 8'h01, 1'b0);
    step(1'b1, 8'h80, 1'b0);
    step(1'b1, 8'h40, 1'b0);
    step(1'b1, 8'h20, 1'b0);
    checks++;
    if (locked !== 1'b0) begin
      errors++;
      $display("FAIL acquire_early: got locked=%b, need 0", locked);
    end
    step(1'b1, 8'h10, 1'b0);
    checks++;
    if (locked !== 1'b1 || err_cnt !== 8'h00) begin
      errors++;
      $display("FAIL acquire_lock: got locked=%b err=%h, need 1/00", locked, err_cnt);
    end
  endtask

  task automatic test_single_error();
    cur_test = "single_error";
    apply_reset();
    lock_up();
    step(1'b1, 8'h08, 1'b0);
    step(1'b1, 8'hFF, 1'b0);
    step(1'b1, 8'hC2, 1'b0);
    checks++;
    if ({locked, err_cnt, seg_lo, seg_hi} !== {1'b1, 8'h01, 8'h9E, 8'h02}) begin
      errors++;
      $display("FAIL single_error: got %b/%h/%h/%h, need 1/01/9E/02", locked, err_cnt, seg_lo, seg_hi);
    end
    // two more misses must not drop lock if the miss run was cleared by C2
    step(1'b1, 8'h00, 1'b0);
    step(1'b1, 8'h00, 1'b0);
    checks++;
    if (locked !== 1'b1 || err_cnt !== 8'h03) begin
      errors++;
      $display("FAIL miss_cleared: got locked=%b err=%h, need 1/03", locked, err_cnt);
    end
  endtask

  task automatic test_lock_loss();
    cur_test = "lock_loss";
    apply_reset();
    lock_up();
    step(1'b1, 8'h00, 1'b0);
    step(1'b1, 8'h00, 1'b0);
    checks++;
    if (locked !== 1'b1) begin
      errors++;
      $display("FAIL loss_early: got locked=%b, need 1", locked);
    end
    step(1'b1, 8'h00, 1'b0);
    checks++;
    if (locked !== 1'b0 || err_cnt !== 8'h03) begin
      errors++;
      $display("FAIL loss_drop: got locked=%b err=%h, need 0/03", locked, err_cnt);
    end
    step(1'b1, 8'h01, 1'b0);
    step(1'b1, 8'h80, 1'b0);
    step(1'b1, 8'h40, 1'b0);
    step(1'b1, 8'h20, 1'b0);
    checks++;
    if (locked !== 1'b0) begin
      errors++;
      $display("FAIL relock_early: got locked=%b, need 0", locked);
    end
    step(1'b1, 8'h10, 1'b0);
    checks++;
    if (locked !== 1'b1 || err_cnt !== 8'h03) begin
      errors++;
      $display("FAIL relock: got locked=%b err=%h, need 1/03", locked, err_cnt);
    end
  endtask

  task automatic gap2();
    step(1'b0, 8'($urandom_range(255)), 1'b0);
    step(1'b0, 8'($urandom_range(255)), 1'b0);
  endtask

  task automatic test_reseed_gaps();
    logic [7:0] w;
    cur_test = "reseed_gaps";
    apply_reset();
    step(1'b1, 8'h01, 1'b0); gap2();
    step(1'b1, 8'h80, 1'b0); gap2();
    step(1'b1, 8'h55, 1'b0); gap2();
    w = 8'h55;
    for (int i = 1; i <= 4; i++) begin
      w = ref_nx(w);
      step(1'b1, w, 1'b0);
      checks++;
      if (locked !== (i == 4)) begin
        errors++;
        $display("FAIL reseed_word%0d: got locked=%b, need %b", i, locked, (i == 4));
      end
      gap2();
    end
  endtask

  task automatic test_saturation();
    cur_test = "saturation";
    apply_reset();
    lock_up();
    for (int i = 0; i < 300; i++) begin
      step(1'b1, ~m_exp, 1'b0);
      if (i % 2 == 1) step(1'b1, m_exp, 1'b0);
    end
    checks++;
    if ({locked, err_cnt, seg_lo, seg_hi} !== {1'b1, 8'hFF, 8'h70, 8'h70}) begin
      errors++;
      $display("FAIL saturate: got %b/%h/%h/%h, need 1/FF/70/70", locked, err_cnt, seg_lo, seg_hi);
    end
    step(1'b1, ~m_exp, 1'b1);
    checks++;
    if ({locked, err_cnt, seg_lo, seg_hi} !== {1'b1, 8'h00, 8'h02, 8'h02}) begin
      errors++;
      $display("FAIL clear_wins: got %b/%h/%h/%h, need 1/00/02/02", locked, err_cnt, seg_lo, seg_hi);
    end
    step(1'b1, ~m_exp, 1'b0);
    step(1'b1, m_exp, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0; valid = 1'b0; data_in = 8'h00; clr_err = 1'b0;
    model_reset();
    test_reset();
    test_mid_reset();
    test_acquire();
    test_single_error();
    test_lock_loss();
    test_reseed_gaps();
    test_saturation();
    repeat (2) @(posedge clk);
    #3;
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending, need 0", sb_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
